share_zero_stream: RTL and testbench
====================================

Name: share_zero_stream

Overview:
Streaming generator of fresh Boolean zero-sharings for masked AES datapaths (refresh gadgets, share-domain remasking). It takes raw PRNG words over a valid/ready handshake and expands them, per lane, into NUM_SHARES shares whose XOR is zero. Results are buffered in a DEPTH-entry FIFO and delivered to the consumer over a second valid/ready handshake. This decouples PRNG bursts from pipeline demand and supports any share count and multiple lanes.

Parameters:
NUM_SHARES, 2, number of output shares per lane; legal range 2..8, elaboration $error outside it.
BIT_WIDTH, 8, bits per share.
NUM_LANES, 1, independent zero-sharings produced per FIFO entry.
DEPTH, 4, FIFO entries; legal range 1..16.
MODE, 0, 0 = ring (share i = r[i] ^ r[(i+1) mod N]); 1 = minimal (shares 0..N-2 = r[i], share N-1 = XOR of r[0..N-2]).
NUM_NEEDED, derived, random words per lane: MODE 1 or NUM_SHARES==2 -> NUM_SHARES-1; otherwise NUM_SHARES.

Ports:
in_clock  input  1  clock, rising edge.
in_reset  input  1  reset, asynchronous, active-low.
in_random  input  NUM_LANES*NUM_NEEDED*BIT_WIDTH  PRNG words, lane-major; word j of lane l at bits [(l*NUM_NEEDED+j)*BIT_WIDTH +: BIT_WIDTH].
in_valid  input  1  in_random is valid.
out_in_ready  output  1  block accepts in_random this cycle.
out_random  output  NUM_LANES*NUM_SHARES*BIT_WIDTH  zero-sharings, lane-major, share i of lane l at [(l*NUM_SHARES+i)*BIT_WIDTH +: BIT_WIDTH].
out_valid  output  1  out_random holds an unconsumed entry.
in_ready  input  1  consumer accepts out_random.
out_fill  output  $clog2(DEPTH+1)  current FIFO occupancy.
out_starved  output  1  sticky: set when in_ready=1 while out_valid=0; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): FIFO storage, pointers and out_fill = 0; out_valid=0; out_starved=0; out_random=0; out_in_ready=0 while in_reset is low.
- out_in_ready = (out_fill < DEPTH). No combinational path from in_ready to out_in_ready. A full FIFO refuses input even when a pop occurs in the same cycle.
- Push on in_valid & out_in_ready. The combinational expansion per MODE is written into the FIFO at the clock edge. Each accepted PRNG word is used in exactly one entry and is never reused.
- Pop on out_valid & in_ready. The read pointer advances, and the popped slot is overwritten with zero in the same edge so no stale randomness is retained.
- out_valid = (out_fill != 0). out_random = head entry when valid, all-zero when not valid.
- Latency: a word accepted at edge t is visible on out_random after edge t when the FIFO was empty. Minimum latency is 1 cycle; there is no fall-through.
- Simultaneous push and pop with 0 < fill < DEPTH: fill unchanged, both pointers advance. With fill==0 only a push is possible.
- Pointers wrap modulo DEPTH; non-power-of-two DEPTH is supported.
- Invariant: for every lane of every entry, the XOR of all NUM_SHARES shares is 0.
- Reset asserted mid-stream: all buffered entries are discarded immediately, with no partial output.

Test Plan:
- NUM_SHARES=3, BIT_WIDTH=2, MODE=0, push lane words r=(1,2,3) -> next cycle out_random shares (3,1,2), out_valid=1, out_fill=1.
- NUM_SHARES=3, BIT_WIDTH=2, MODE=1, push r=(1,2) -> shares (1,2,3). NUM_SHARES=2, MODE=0, push r=5 -> shares (5,5).
- DEPTH=4, in_ready=0, in_valid held high for 6 cycles -> exactly 4 accepted, out_in_ready=0 at out_fill=4. Then assert in_ready -> entries emerge in push order, and out_random=0 once the FIFO is empty.
- DEPTH=3, continuous in_valid=1 and in_ready=1 for 20 cycles with random words -> out_fill stays 1, order is preserved, and XOR of shares is 0 every cycle.
- in_ready=1 at an empty FIFO after reset -> out_starved=1 and stays high through later traffic; drop in_reset with 2 entries buffered -> out_valid=0, out_fill=0 and out_random=0 immediately.
- NUM_LANES=2, NUM_SHARES=4, MODE=0, 1000 random pushes/pops against a reference model -> bit-exact match and per-lane zero-XOR.

Source files
------------

// File: rtl/share_zero_stream.sv
// Streaming zero-sharing generator: expands PRNG words into NUM_SHARES shares
// per lane whose XOR is zero, buffered in a DEPTH-entry FIFO with valid/ready on both sides.
module share_zero_stream #(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_LANES  = 1,
  parameter int DEPTH      = 4,
  parameter int MODE       = 0,
  localparam int NUM_NEEDED = (MODE == 1 || NUM_SHARES == 2) ? NUM_SHARES - 1 : NUM_SHARES,
  localparam int IN_W       = NUM_LANES * NUM_NEEDED * BIT_WIDTH,
  localparam int OUT_W      = NUM_LANES * NUM_SHARES * BIT_WIDTH,
  localparam int FILL_W     = $clog2(DEPTH + 1)
) (
  input  logic              in_clock,
  input  logic              in_reset,
  input  logic [IN_W-1:0]   in_random,
  input  logic              in_valid,
  output logic              out_in_ready,
  output logic [OUT_W-1:0]  out_random,
  output logic              out_valid,
  input  logic              in_ready,
  output logic [FILL_W-1:0] out_fill,
  output logic              out_starved
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (NUM_SHARES < 2 || NUM_SHARES > 8) begin : g_bad_shares
    $error("share_zero_stream: NUM_SHARES must be in 2..8");
  end
  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("share_zero_stream: DEPTH must be in 1..16");
  end

  logic [OUT_W-1:0]  expand;
  logic [OUT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              starved_q, starved_d;
  logic              push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ring mode needs one word per share; minimal mode closes the sharing with an XOR of the rest.
  if (NUM_NEEDED == NUM_SHARES) begin : g_ring
    always_comb begin
      expand = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        for (int i = 0; i < NUM_SHARES; i++) begin
          expand[(l*NUM_SHARES+i)*BIT_WIDTH +: BIT_WIDTH] =
            in_random[(l*NUM_NEEDED+i)*BIT_WIDTH +: BIT_WIDTH] ^
            in_random[(l*NUM_NEEDED+((i+1)%NUM_SHARES))*BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end
  end else begin : g_min
    always_comb begin : p_min
      logic [BIT_WIDTH-1:0] acc;
      expand = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        acc = '0;
        for (int i = 0; i < NUM_NEEDED; i++) begin
          expand[(l*NUM_SHARES+i)*BIT_WIDTH +: BIT_WIDTH] =
            in_random[(l*NUM_NEEDED+i)*BIT_WIDTH +: BIT_WIDTH];
          acc = acc ^ in_random[(l*NUM_NEEDED+i)*BIT_WIDTH +: BIT_WIDTH];
        end
        expand[(l*NUM_SHARES+NUM_SHARES-1)*BIT_WIDTH +: BIT_WIDTH] = acc;
      end
    end
  end

  // Readiness depends only on registered fill, so a full FIFO refuses input even during a pop.
  assign out_in_ready = in_reset && (fill_q < FILL_W'(DEPTH));
  assign out_valid    = (fill_q != '0);
  assign out_random   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_fill     = fill_q;
  assign out_starved  = starved_q;
  assign push         = in_valid && out_in_ready;
  assign pop          = out_valid && in_ready;

  always_comb begin
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fill_d    = fill_q;
    if (push && !pop) fill_d = fill_q + 1'b1;
    if (pop && !push) fill_d = fill_q - 1'b1;
    starved_d = starved_q || (in_ready && !out_valid);
  end

  // Popped slots are scrubbed so no consumed randomness lingers in storage.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      starved_q <= 1'b0;
    end else begin
      if (pop)  mem_q[rd_ptr_q] <= '0;
      if (push) mem_q[wr_ptr_q] <= expand;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      starved_q <= starved_d;
    end
  end

endmodule

// File: tb/tb_share_zero_stream.sv
// Bench for share_zero_stream across ring/minimal modes, several depths and two lanes.
module tb_share_zero_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // a: N=3 W=2 ring, DEPTH=4
  logic [5:0] a_rnd, a_out; logic a_vld, a_rdy, a_irdy, a_ovld, a_starv; logic [2:0] a_fill;
  // b: N=3 W=2 minimal, DEPTH=3
  logic [3:0] b_rnd; logic [5:0] b_out; logic b_vld, b_rdy, b_irdy, b_ovld, b_starv; logic [1:0] b_fill;
  // c: N=4 W=8 ring, 2 lanes, DEPTH=4
  logic [63:0] c_rnd, c_out; logic c_vld, c_rdy, c_irdy, c_ovld, c_starv; logic [2:0] c_fill;
  // d: N=2 W=8, DEPTH=2
  logic [7:0] d_rnd; logic [15:0] d_out; logic d_vld, d_rdy, d_irdy, d_ovld, d_starv; logic [1:0] d_fill;

  share_zero_stream #(.NUM_SHARES(3), .BIT_WIDTH(2), .NUM_LANES(1), .DEPTH(4), .MODE(0)) u_a (
    .in_clock(clk), .in_reset(rst_n), .in_random(a_rnd), .in_valid(a_vld), .out_in_ready(a_irdy),
    .out_random(a_out), .out_valid(a_ovld), .in_ready(a_rdy), .out_fill(a_fill), .out_starved(a_starv));
  share_zero_stream #(.NUM_SHARES(3), .BIT_WIDTH(2), .NUM_LANES(1), .DEPTH(3), .MODE(1)) u_b (
    .in_clock(clk), .in_reset(rst_n), .in_random(b_rnd), .in_valid(b_vld), .out_in_ready(b_irdy),
    .out_random(b_out), .out_valid(b_ovld), .in_ready(b_rdy), .out_fill(b_fill), .out_starved(b_starv));
  share_zero_stream #(.NUM_SHARES(4), .BIT_WIDTH(8), .NUM_LANES(2), .DEPTH(4), .MODE(0)) u_c (
    .in_clock(clk), .in_reset(rst_n), .in_random(c_rnd), .in_valid(c_vld), .out_in_ready(c_irdy),
    .out_random(c_out), .out_valid(c_ovld), .in_ready(c_rdy), .out_fill(c_fill), .out_starved(c_starv));
  share_zero_stream #(.NUM_SHARES(2), .BIT_WIDTH(8), .NUM_LANES(1), .DEPTH(2), .MODE(0)) u_d (
    .in_clock(clk), .in_reset(rst_n), .in_random(d_rnd), .in_valid(d_vld), .out_in_ready(d_irdy),
    .out_random(d_out), .out_valid(d_ovld), .in_ready(d_rdy), .out_fill(d_fill), .out_starved(d_starv));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          inst;
    logic [15:0] rnd;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [12];
  logic [5:0]  qa [$];
  logic [5:0]  qb [$];
  logic [63:0] qc [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] ring3(input logic [5:0] r);
    return {r[5:4] ^ r[1:0], r[3:2] ^ r[5:4], r[1:0] ^ r[3:2]};
  endfunction

  function automatic logic [5:0] min3(input logic [3:0] r);
    return {r[3:2] ^ r[1:0], r[3:2], r[1:0]};
  endfunction

  function automatic logic [63:0] ref4(input logic [63:0] r);
    logic [63:0] s;
    s = '0;
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < 4; i++)
        s[(l*4+i)*8 +: 8] = r[(l*4+i)*8 +: 8] ^ r[(l*4+((i+1)%4))*8 +: 8];
    return s;
  endfunction

  function automatic logic [15:0] lane_xor(input logic [63:0] s);
    return {s[63:56] ^ s[55:48] ^ s[47:40] ^ s[39:32], s[31:24] ^ s[23:16] ^ s[15:8] ^ s[7:0]};
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int sz;
    logic [63:0] o;
    logic ov;
    logic [63:0] fl;

    tbl[0]  = '{0, 16'h0039, 16'h0027};
    tbl[1]  = '{0, 16'h0000, 16'h0000};
    tbl[2]  = '{0, 16'h0003, 16'h0033};
    tbl[3]  = '{0, 16'h0025, 16'h003C};
    tbl[4]  = '{0, 16'h003F, 16'h0000};
    tbl[5]  = '{0, 16'h0006, 16'h0027};
    tbl[6]  = '{1, 16'h0009, 16'h0039};
    tbl[7]  = '{1, 16'h000F, 16'h000F};
    tbl[8]  = '{1, 16'h0008, 16'h0028};
    tbl[9]  = '{1, 16'h0001, 16'h0011};
    tbl[10] = '{2, 16'h0005, 16'h0505};
    tbl[11] = '{2, 16'h00A3, 16'hA3A3};

    rst_n = 1'b0;
    a_rnd = '0; a_vld = 0; a_rdy = 0;
    b_rnd = '0; b_vld = 0; b_rdy = 0;
    c_rnd = '0; c_vld = 0; c_rdy = 0;
    d_rnd = '0; d_vld = 0; d_rdy = 0;
    repeat (2) tick();

    chk("rst_in_ready", 64'(a_irdy), 64'(0));
    chk("rst_out_valid", 64'(a_ovld), 64'(0));
    chk("rst_fill", 64'(a_fill), 64'(0));
    chk("rst_out_random", 64'(a_out), 64'(0));
    chk("rst_starved", 64'(a_starv), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(a_irdy), 64'(1));

    // Starvation: consumer ready on an empty FIFO
    a_rdy = 1; tick(); a_rdy = 0;
    chk("starved_set", 64'(a_starv), 64'(1));
    chk("starved_no_valid", 64'(a_ovld), 64'(0));

    // Table-driven single push / single pop per vector
    for (int v = 0; v < 12; v++) begin
      case (tbl[v].inst)
        0: begin a_rnd = tbl[v].rnd[5:0]; a_vld = 1; end
        1: begin b_rnd = tbl[v].rnd[3:0]; b_vld = 1; end
        default: begin d_rnd = tbl[v].rnd[7:0]; d_vld = 1; end
      endcase
      tick();
      a_vld = 0; b_vld = 0; d_vld = 0;
      case (tbl[v].inst)
        0: begin o = 64'(a_out); ov = a_ovld; fl = 64'(a_fill); end
        1: begin o = 64'(b_out); ov = b_ovld; fl = 64'(b_fill); end
        default: begin o = 64'(d_out); ov = d_ovld; fl = 64'(d_fill); end
      endcase
      chk($sformatf("vec%0d_shares", v), o, 64'(tbl[v].exp));
      chk($sformatf("vec%0d_valid", v), 64'(ov), 64'(1));
      chk($sformatf("vec%0d_fill", v), fl, 64'(1));
      a_rdy = (tbl[v].inst == 0); b_rdy = (tbl[v].inst == 1); d_rdy = (tbl[v].inst == 2);
      tick();
      a_rdy = 0; b_rdy = 0; d_rdy = 0;
      case (tbl[v].inst)
        0: begin o = 64'(a_out); ov = a_ovld; end
        1: begin o = 64'(b_out); ov = b_ovld; end
        default: begin o = 64'(d_out); ov = d_ovld; end
      endcase
      chk($sformatf("vec%0d_drained_out", v), o, 64'(0));
      chk($sformatf("vec%0d_drained_valid", v), 64'(ov), 64'(0));
    end

    // Backpressure: six offered words, four fit
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      a_rnd = 6'($urandom);
      a_vld = 1;
      if (qa.size() < 4) qa.push_back(ring3(a_rnd));
      if (a_irdy) acc++;
      tick();
    end
    chk("bp_accepted", 64'(acc), 64'(4));
    chk("bp_fill_full", 64'(a_fill), 64'(4));
    chk("bp_in_ready_full", 64'(a_irdy), 64'(0));
    a_rdy = 1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_drain%0d", k), 64'(a_out), 64'(qa.pop_front()));
      tick();
      a_vld = 0;
      chk($sformatf("bp_fill%0d", k), 64'(a_fill), 64'(3 - k));
    end
    a_rdy = 0;
    chk("bp_empty_out", 64'(a_out), 64'(0));
    chk("bp_empty_valid", 64'(a_ovld), 64'(0));

    // Continuous streaming through DEPTH=3 minimal-mode FIFO
    b_vld = 1; b_rdy = 1;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("st_fill%0d", k), 64'(b_fill), 64'(qb.size()));
      if (qb.size() != 0) begin
        chk($sformatf("st_out%0d", k), 64'(b_out), 64'(qb[0]));
        chk($sformatf("st_xor%0d", k), 64'(b_out[1:0] ^ b_out[3:2] ^ b_out[5:4]), 64'(0));
        void'(qb.pop_front());
      end
      b_rnd = 4'($urandom);
      qb.push_back(min3(b_rnd));
      tick();
    end
    b_vld = 0;
    tick();
    b_rdy = 0;
    chk("st_final_empty", 64'(b_ovld), 64'(0));

    // Randomised two-lane traffic against the scoreboard
    for (int k = 0; k < 1000; k++) begin
      sz = qc.size();
      chk("rnd_in_ready", 64'(c_irdy), 64'(sz < 4));
      chk("rnd_fill", 64'(c_fill), 64'(sz));
      chk("rnd_valid", 64'(c_ovld), 64'(sz != 0));
      chk("rnd_out", c_out, (sz != 0) ? qc[0] : 64'(0));
      chk("rnd_lane_xor", 64'(lane_xor(c_out)), 64'(0));
      c_vld = 1'($urandom_range(0, 1));
      c_rdy = 1'($urandom_range(0, 1));
      c_rnd = {$urandom, $urandom};
      if (c_rdy && sz != 0) void'(qc.pop_front());
      if (c_vld && sz < 4) qc.push_back(ref4(c_rnd));
      tick();
    end
    c_vld = 0; c_rdy = 0;

    chk("starved_sticky", 64'(a_starv), 64'(1));

    // Reset with two entries buffered
    a_vld = 1; a_rnd = 6'h15;
    repeat (2) tick();
    a_vld = 0;
    chk("mid_fill_before", 64'(a_fill), 64'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(a_ovld), 64'(0));
    chk("mid_rst_fill", 64'(a_fill), 64'(0));
    chk("mid_rst_out", 64'(a_out), 64'(0));
    chk("mid_rst_in_ready", 64'(a_irdy), 64'(0));
    chk("mid_rst_starved", 64'(a_starv), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_mid_valid", 64'(a_ovld), 64'(0));
    chk("post_mid_fill", 64'(a_fill), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
